// File: rtl/bus_grant_if.sv
// Bus-grant handshake bundle between the grant controller and its environment.
//   Inputs to the controller:
//     mc_clk_fall   one-cycle strobe per falling edge of CLK_7M
//     req_pi/aux    access requests, held until the matching done pulse
//     cyc_done      end-of-access pulse from the bus-cycle engine
//     bg_n, as_n, dtack_n, bgack_n   synchronized bus lines
//     force_release level request to give the bus back
//   Outputs from the controller:
//     br_drive, bgack_drive   open-drain enables (1 pulls the line low)
//     grant_pi/aux            one-hot grant to the engine
//     done_pi/aux             one-cycle completion pulses
//     bus_owned, bg_timeout   status
interface bus_grant_if;
  logic mc_clk_fall;
  logic req_pi;
  logic req_aux;
  logic cyc_done;
  logic bg_n;
  logic as_n;
  logic dtack_n;
  logic bgack_n;
  logic force_release;

  logic br_drive;
  logic bgack_drive;
  logic grant_pi;
  logic grant_aux;
  logic done_pi;
  logic done_aux;
  logic bus_owned;
  logic bg_timeout;

  modport master (
    input  mc_clk_fall, req_pi, req_aux, cyc_done,
           bg_n, as_n, dtack_n, bgack_n, force_release,
    output br_drive, bgack_drive, grant_pi, grant_aux,
           done_pi, done_aux, bus_owned, bg_timeout
  );

  modport slave (
    output mc_clk_fall, req_pi, req_aux, cyc_done,
           bg_n, as_n, dtack_n, bgack_n, force_release,
    input  br_drive, bgack_drive, grant_pi, grant_aux,
           done_pi, done_aux, bus_owned, bg_timeout
  );
endinterface

// File: rtl/bus_grant_ctrl.sv
// Bus-grant controller: runs the BR / BG / BGACK arbitration sequence to take
// the bus for two local requesters (pi, aux), grants them round-robin while
// the bus is owned, and hands the bus back after an idle period, on request,
// or abandons the attempt after a BG timeout.
//   sys_clk  system clock, all logic on its rising edge
//   nRESET   asynchronous active-low reset
//   bus      bus_grant_if.master (requests, bus lines, strobe, grants, status)
// All outputs come straight from flops.
module bus_grant_ctrl #(
  parameter int IDLE_HOLD  = 16,
  parameter int BG_TIMEOUT = 255
) (
  input  logic         sys_clk,
  input  logic         nRESET,
  bus_grant_if.master  bus
);

  localparam int TMO_W  = $clog2(BG_TIMEOUT) + 1;
  localparam int IDLE_W = $clog2(IDLE_HOLD) + 1;
  localparam logic [TMO_W-1:0]  TMO_LIMIT  = TMO_W'(BG_TIMEOUT);
  localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(IDLE_HOLD);
  localparam logic [TMO_W-1:0]  TMO_ONE    = TMO_W'(1);
  localparam logic [IDLE_W-1:0] IDLE_ONE   = IDLE_W'(1);

  typedef enum logic [2:0] {
    S_RELEASED,
    S_REQUEST,
    S_WAIT_BUS,
    S_OWNED,
    S_BUSY,
    S_RELEASE
  } state_t;

  state_t              state;
  logic [TMO_W-1:0]    tmo_cnt;
  logic [IDLE_W-1:0]   idle_cnt;
  logic                last_aux;

  logic br_drive_r;
  logic bgack_drive_r;
  logic grant_pi_r;
  logic grant_aux_r;
  logic done_pi_r;
  logic done_aux_r;
  logic bus_owned_r;
  logic bg_timeout_r;

  logic                any_req;
  logic                pick_aux;
  logic                bus_free;
  logic [IDLE_W-1:0]   idle_next;

  function automatic logic [TMO_W-1:0] sat_inc_tmo(input logic [TMO_W-1:0] v);
    return (&v) ? v : v + TMO_ONE;
  endfunction

  function automatic logic [IDLE_W-1:0] sat_inc_idle(input logic [IDLE_W-1:0] v);
    return (&v) ? v : v + IDLE_ONE;
  endfunction

  assign any_req   = bus.req_pi | bus.req_aux;
  // Aux wins when it is alone, or when both ask and pi was served last.
  assign pick_aux  = bus.req_aux & (~bus.req_pi | ~last_aux);
  assign bus_free  = bus.mc_clk_fall & bus.as_n & bus.dtack_n & bus.bgack_n;
  assign idle_next = bus.mc_clk_fall ? sat_inc_idle(idle_cnt) : idle_cnt;

  always_ff @(posedge sys_clk or negedge nRESET) begin
    if (!nRESET) begin
      state         <= S_RELEASED;
      tmo_cnt       <= '0;
      idle_cnt      <= '0;
      last_aux      <= 1'b1;
      br_drive_r    <= 1'b0;
      bgack_drive_r <= 1'b0;
      grant_pi_r    <= 1'b0;
      grant_aux_r   <= 1'b0;
      done_pi_r     <= 1'b0;
      done_aux_r    <= 1'b0;
      bus_owned_r   <= 1'b0;
      bg_timeout_r  <= 1'b0;
    end else begin
      done_pi_r  <= 1'b0;
      done_aux_r <= 1'b0;
      case (state)
        S_RELEASED: begin
          if (any_req) begin
            br_drive_r <= 1'b1;
            tmo_cnt    <= '0;
            state      <= S_REQUEST;
          end
        end
        S_REQUEST: begin
          if (bus.force_release) begin
            br_drive_r <= 1'b0;
            state      <= S_RELEASED;
          end else if (tmo_cnt == TMO_LIMIT) begin
            br_drive_r   <= 1'b0;
            bg_timeout_r <= 1'b1;
            state        <= S_RELEASED;
          end else if (bus.mc_clk_fall) begin
            if (!bus.bg_n) state <= S_WAIT_BUS;
            else           tmo_cnt <= sat_inc_tmo(tmo_cnt);
          end
        end
        S_WAIT_BUS: begin
          if (bus.force_release) begin
            br_drive_r <= 1'b0;
            state      <= S_RELEASED;
          end else if (bus_free) begin
            // BR and BGACK swap in the same edge so they never overlap.
            bgack_drive_r <= 1'b1;
            bus_owned_r   <= 1'b1;
            br_drive_r    <= 1'b0;
            bg_timeout_r  <= 1'b0;
            idle_cnt      <= '0;
            state         <= S_OWNED;
          end
        end
        S_OWNED: begin
          if (bus.force_release) begin
            state <= S_RELEASE;
          end else if (any_req) begin
            grant_aux_r <= pick_aux;
            grant_pi_r  <= ~pick_aux;
            last_aux    <= pick_aux;
            idle_cnt    <= '0;
            state       <= S_BUSY;
          end else if (idle_next >= IDLE_LIMIT) begin
            state <= S_RELEASE;
          end else begin
            idle_cnt <= idle_next;
          end
        end
        S_BUSY: begin
          if (bus.cyc_done) begin
            done_pi_r   <= grant_pi_r;
            done_aux_r  <= grant_aux_r;
            grant_pi_r  <= 1'b0;
            grant_aux_r <= 1'b0;
            idle_cnt    <= '0;
            state       <= bus.force_release ? S_RELEASE : S_OWNED;
          end
        end
        S_RELEASE: begin
          bgack_drive_r <= 1'b0;
          bus_owned_r   <= 1'b0;
          state         <= S_RELEASED;
        end
        default: state <= S_RELEASED;
      endcase
    end
  end

  assign bus.br_drive    = br_drive_r;
  assign bus.bgack_drive = bgack_drive_r;
  assign bus.grant_pi    = grant_pi_r;
  assign bus.grant_aux   = grant_aux_r;
  assign bus.done_pi     = done_pi_r;
  assign bus.done_aux    = done_aux_r;
  assign bus.bus_owned   = bus_owned_r;
  assign bus.bg_timeout  = bg_timeout_r;

endmodule

// File: tb/tb_bus_grant_ctrl.sv
// Bench for bus_grant_ctrl: randomized strobe spacing, bus latencies, access
// lengths and request mixes, checked against a round-robin reference model.
module tb_bus_grant_ctrl;
  localparam int IDLE_HOLD  = 16;
  localparam int BG_TIMEOUT = 255;

  logic sys_clk = 1'b0;
  logic nRESET  = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  logic exp_last_aux;   // reference model: requester served most recently
  logic [7:0] outs;

  bus_grant_if bus ();

  bus_grant_ctrl #(.IDLE_HOLD(IDLE_HOLD), .BG_TIMEOUT(BG_TIMEOUT)) dut (
    .sys_clk (sys_clk),
    .nRESET  (nRESET),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  assign outs = {bus.br_drive, bus.bgack_drive, bus.grant_pi, bus.grant_aux,
                 bus.done_pi, bus.done_aux, bus.bus_owned, bus.bg_timeout};

  // One sys_clk cycle; outputs are sampled 1 time unit after the edge.
  task automatic cyc(input bit s);
    bus.mc_clk_fall = s;
    @(posedge sys_clk);
    #1;
    bus.mc_clk_fall = 1'b0;
    bus.cyc_done    = 1'b0;
  endtask

  // A random gap of plain cycles followed by one strobe cycle.
  task automatic strobe();
    repeat ($urandom_range(1, 3)) cyc(1'b0);
    cyc(1'b1);
  endtask

  // Stimulus only: BG after `pre` strobes, bus busy for `busy` strobes.
  task automatic acquire(input int pre, input int busy);
    bus.bg_n = 1'b1;
    repeat (pre) strobe();
    bus.bg_n = 1'b0;
    strobe();
    for (int k = 0; k < busy; k++) begin
      bus.as_n = 1'b1; bus.dtack_n = 1'b1; bus.bgack_n = 1'b1;
      case ($urandom_range(0, 2))
        0: bus.as_n = 1'b0;
        1: bus.dtack_n = 1'b0;
        default: bus.bgack_n = 1'b0;
      endcase
      strobe();
    end
    bus.as_n = 1'b1; bus.dtack_n = 1'b1; bus.bgack_n = 1'b1;
    strobe();
    bus.bg_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.req_pi = 1'b1;
    #1;
    checks++; if (outs !== 8'h00) begin failures++; $display("FAIL reset_outputs: got %b want 00000000", outs); end
    repeat (3) @(posedge sys_clk);
    #1;
    checks++; if (outs !== 8'h00) begin failures++; $display("FAIL reset_held: got %b want 00000000", outs); end
    bus.req_pi = 1'b0;
    nRESET = 1'b1;
    exp_last_aux = 1'b1;
    cyc(1'b0);
    checks++; if (outs !== 8'h00) begin failures++; $display("FAIL reset_idle: got %b want 00000000", outs); end
  endtask

  task automatic test_single();
    logic who;
    logic bad;
    who = 1'($urandom_range(0, 1));
    if (who) bus.req_aux = 1'b1; else bus.req_pi = 1'b1;
    cyc(1'b0);
    checks++; if (bus.br_drive !== 1'b1 || bus.bgack_drive !== 1'b0) begin failures++; $display("FAIL single_br_assert: br=%b bgack=%b want br=1 bgack=0", bus.br_drive, bus.bgack_drive); end
    bad = 1'b0;
    bus.bg_n = 1'b1;
    repeat ($urandom_range(1, 5)) begin
      strobe();
      if (bus.br_drive !== 1'b1 || bus.bgack_drive !== 1'b0) bad = 1'b1;
    end
    bus.bg_n = 1'b0;
    strobe();
    if (bus.br_drive !== 1'b1 || bus.bgack_drive !== 1'b0) bad = 1'b1;
    repeat ($urandom_range(1, 5)) begin
      bus.as_n = 1'b1; bus.dtack_n = 1'b1; bus.bgack_n = 1'b1;
      case ($urandom_range(0, 2))
        0: bus.as_n = 1'b0;
        1: bus.dtack_n = 1'b0;
        default: bus.bgack_n = 1'b0;
      endcase
      strobe();
      if (bus.br_drive !== 1'b1 || bus.bgack_drive !== 1'b0) bad = 1'b1;
    end
    bus.as_n = 1'b1; bus.dtack_n = 1'b1; bus.bgack_n = 1'b1;
    cyc(1'b0);
    if (bus.bgack_drive !== 1'b0) bad = 1'b1;
    checks++; if (bad) begin failures++; $display("FAIL single_wait_phase: bgack rose or br dropped early, want br=1 bgack=0 until a free strobe"); end
    strobe();
    bus.bg_n = 1'b1;
    checks++; if ({bus.bgack_drive, bus.br_drive, bus.bus_owned, bus.grant_pi, bus.grant_aux} !== 5'b10100) begin failures++; $display("FAIL single_owned_entry: got %b want 10100", {bus.bgack_drive, bus.br_drive, bus.bus_owned, bus.grant_pi, bus.grant_aux}); end
    cyc(1'b0);
    checks++; if ({bus.grant_pi, bus.grant_aux} !== {~who, who}) begin failures++; $display("FAIL single_grant: got %b want %b", {bus.grant_pi, bus.grant_aux}, {~who, who}); end
    exp_last_aux = who;
    bad = 1'b0;
    repeat ($urandom_range(1, 6)) begin
      cyc(1'b0);
      if ({bus.grant_pi, bus.grant_aux, bus.done_pi, bus.done_aux} !== {~who, who, 2'b00}) bad = 1'b1;
    end
    checks++; if (bad) begin failures++; $display("FAIL single_grant_stable: grant changed or done pulsed before cyc_done"); end
    bus.cyc_done = 1'b1;
    cyc(1'b0);
    checks++; if ({bus.done_pi, bus.done_aux, bus.grant_pi, bus.grant_aux} !== {~who, who, 2'b00}) begin failures++; $display("FAIL single_done: got %b want %b", {bus.done_pi, bus.done_aux, bus.grant_pi, bus.grant_aux}, {~who, who, 2'b00}); end
    bus.req_pi = 1'b0; bus.req_aux = 1'b0;
    cyc(1'b0);
    checks++; if ({bus.done_pi, bus.done_aux} !== 2'b00) begin failures++; $display("FAIL single_done_width: got %b want 00", {bus.done_pi, bus.done_aux}); end
    bus.cyc_done = 1'b1;
    cyc(1'b0);
    checks++; if ({bus.done_pi, bus.done_aux, bus.bgack_drive} !== 3'b001) begin failures++; $display("FAIL single_stray_done: got %b want 001", {bus.done_pi, bus.done_aux, bus.bgack_drive}); end
    bad = 1'b0;
    for (int k = 1; k < IDLE_HOLD; k++) begin
      strobe();
      if (bus.bgack_drive !== 1'b1) bad = 1'b1;
    end
    checks++; if (bad) begin failures++; $display("FAIL single_idle_hold: bgack dropped before %0d idle strobes", IDLE_HOLD); end
    strobe();
    cyc(1'b0);
    checks++; if ({bus.bgack_drive, bus.bus_owned, bus.br_drive} !== 3'b000) begin failures++; $display("FAIL single_release: got %b want 000", {bus.bgack_drive, bus.bus_owned, bus.br_drive}); end
  endtask

  task automatic test_contention();
    int   n;
    int   sel;
    logic exp_aux;
    logic bad;
    n = 8 + $urandom_range(0, 2);
    bus.req_pi = 1'b1; bus.req_aux = 1'b1;
    cyc(1'b0);
    acquire($urandom_range(0, 3), $urandom_range(0, 3));
    checks++; if (bus.bgack_drive !== 1'b1) begin failures++; $display("FAIL cont_acquire: bgack=%b want 1", bus.bgack_drive); end
    for (int i = 0; i < n; i++) begin
      sel = 3;
      if (i >= 4) begin
        bus.req_pi = 1'b0; bus.req_aux = 1'b0;
        repeat ($urandom_range(0, 6)) strobe();
        sel = $urandom_range(1, 3);
        bus.req_pi  = (sel != 2);
        bus.req_aux = (sel != 1);
      end
      cyc(1'b0);
      exp_aux = (sel == 2) || (sel == 3 && !exp_last_aux);
      checks++; if ({bus.grant_pi, bus.grant_aux, bus.bgack_drive} !== {~exp_aux, exp_aux, 1'b1}) begin failures++; $display("FAIL cont_grant[%0d]: got %b want %b", i, {bus.grant_pi, bus.grant_aux, bus.bgack_drive}, {~exp_aux, exp_aux, 1'b1}); end
      exp_last_aux = exp_aux;
      bad = 1'b0;
      repeat ($urandom_range(0, 4)) begin
        cyc(1'b0);
        if ({bus.grant_pi, bus.grant_aux} !== {~exp_aux, exp_aux}) bad = 1'b1;
      end
      checks++; if (bad) begin failures++; $display("FAIL cont_stable[%0d]: grant moved during access, want %b", i, {~exp_aux, exp_aux}); end
      bus.cyc_done = 1'b1;
      cyc(1'b0);
      checks++; if ({bus.done_pi, bus.done_aux, bus.grant_pi, bus.grant_aux} !== {~exp_aux, exp_aux, 2'b00}) begin failures++; $display("FAIL cont_done[%0d]: got %b want %b", i, {bus.done_pi, bus.done_aux, bus.grant_pi, bus.grant_aux}, {~exp_aux, exp_aux, 2'b00}); end
    end
    bus.req_pi = 1'b0; bus.req_aux = 1'b0;
    bad = 1'b0;
    for (int k = 1; k < IDLE_HOLD; k++) begin
      strobe();
      if (bus.bgack_drive !== 1'b1) bad = 1'b1;
    end
    checks++; if (bad) begin failures++; $display("FAIL cont_idle_hold: bus released before %0d idle strobes", IDLE_HOLD); end
    strobe();
    cyc(1'b0);
    checks++; if (bus.bgack_drive !== 1'b0) begin failures++; $display("FAIL cont_release: bgack=%b want 0", bus.bgack_drive); end
  endtask

  task automatic test_timeout();
    logic bad;
    bus.req_aux = 1'b1;
    bus.bg_n    = 1'b1;
    cyc(1'b0);
    bad = 1'b0;
    for (int k = 0; k < BG_TIMEOUT; k++) begin
      strobe();
      if (bus.br_drive !== 1'b1 || bus.bg_timeout !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad) begin failures++; $display("FAIL tmo_early: br dropped or flag set before %0d strobes", BG_TIMEOUT); end
    cyc(1'b0);
    checks++; if ({bus.br_drive, bus.bg_timeout, bus.bgack_drive} !== 3'b010) begin failures++; $display("FAIL tmo_fire: got %b want 010", {bus.br_drive, bus.bg_timeout, bus.bgack_drive}); end
    bus.req_aux = 1'b0;
    cyc(1'b0);
    checks++; if ({bus.br_drive, bus.bg_timeout} !== 2'b01) begin failures++; $display("FAIL tmo_sticky: got %b want 01", {bus.br_drive, bus.bg_timeout}); end
    bus.req_pi = 1'b1;
    cyc(1'b0);
    checks++; if ({bus.br_drive, bus.bg_timeout} !== 2'b11) begin failures++; $display("FAIL tmo_rerequest: got %b want 11", {bus.br_drive, bus.bg_timeout}); end
    acquire($urandom_range(0, 3), $urandom_range(0, 3));
    checks++; if ({bus.bgack_drive, bus.bg_timeout} !== 2'b10) begin failures++; $display("FAIL tmo_clear: got %b want 10", {bus.bgack_drive, bus.bg_timeout}); end
    cyc(1'b0);
    checks++; if ({bus.grant_pi, bus.grant_aux} !== 2'b10) begin failures++; $display("FAIL tmo_grant: got %b want 10", {bus.grant_pi, bus.grant_aux}); end
    exp_last_aux = 1'b0;
    bus.cyc_done = 1'b1;
    cyc(1'b0);
    bus.req_pi = 1'b0;
    cyc(1'b0);
    bus.force_release = 1'b1;
    cyc(1'b0);
    cyc(1'b0);
    bus.force_release = 1'b0;
    checks++; if ({bus.bgack_drive, bus.bus_owned} !== 2'b00) begin failures++; $display("FAIL tmo_force_idle: got %b want 00", {bus.bgack_drive, bus.bus_owned}); end
  endtask

  task automatic test_force();
    logic bad;
    // Abort from REQUEST.
    bus.req_pi = 1'b1;
    cyc(1'b0);
    bus.bg_n = 1'b1;
    repeat ($urandom_range(1, 3)) strobe();
    bus.force_release = 1'b1;
    cyc(1'b0);
    checks++; if ({bus.br_drive, bus.bg_timeout, bus.bgack_drive} !== 3'b000) begin failures++; $display("FAIL force_request: got %b want 000", {bus.br_drive, bus.bg_timeout, bus.bgack_drive}); end
    bus.force_release = 1'b0; bus.req_pi = 1'b0;
    cyc(1'b0);
    // Abort from WAIT_BUS.
    bus.req_aux = 1'b1;
    cyc(1'b0);
    bus.bg_n = 1'b0;
    strobe();
    bus.as_n = 1'b0;
    strobe();
    bus.force_release = 1'b1; bus.req_aux = 1'b0;
    cyc(1'b0);
    checks++; if ({bus.br_drive, bus.bgack_drive, bus.bg_timeout} !== 3'b000) begin failures++; $display("FAIL force_wait_bus: got %b want 000", {bus.br_drive, bus.bgack_drive, bus.bg_timeout}); end
    bus.force_release = 1'b0; bus.as_n = 1'b1; bus.bg_n = 1'b1;
    cyc(1'b0);
    // force_release beats a request arriving in the same OWNED cycle.
    bus.req_pi = 1'b1;
    cyc(1'b0);
    acquire($urandom_range(0, 3), $urandom_range(0, 3));
    cyc(1'b0);
    exp_last_aux = 1'b0;
    bus.cyc_done = 1'b1;
    cyc(1'b0);
    bus.req_pi = 1'b0;
    cyc(1'b0);
    bus.req_aux = 1'b1; bus.force_release = 1'b1;
    cyc(1'b0);
    checks++; if ({bus.grant_pi, bus.grant_aux, bus.bgack_drive} !== 3'b001) begin failures++; $display("FAIL force_owned_wins: got %b want 001", {bus.grant_pi, bus.grant_aux, bus.bgack_drive}); end
    bus.force_release = 1'b0;
    cyc(1'b0);
    checks++; if ({bus.bgack_drive, bus.br_drive, bus.grant_aux} !== 3'b000) begin failures++; $display("FAIL force_released: got %b want 000", {bus.bgack_drive, bus.br_drive, bus.grant_aux}); end
    cyc(1'b0);
    checks++; if (bus.br_drive !== 1'b1) begin failures++; $display("FAIL force_fresh_br: br=%b want 1", bus.br_drive); end
    // force_release during a pi access with aux waiting.
    acquire($urandom_range(0, 3), $urandom_range(0, 3));
    cyc(1'b0);
    checks++; if ({bus.grant_pi, bus.grant_aux} !== 2'b01) begin failures++; $display("FAIL force_aux_grant: got %b want 01", {bus.grant_pi, bus.grant_aux}); end
    exp_last_aux = 1'b1;
    bus.req_pi = 1'b1; bus.cyc_done = 1'b1;
    cyc(1'b0);
    bus.req_aux = 1'b0;
    cyc(1'b0);
    checks++; if ({bus.grant_pi, bus.grant_aux} !== 2'b10) begin failures++; $display("FAIL force_pi_grant: got %b want 10", {bus.grant_pi, bus.grant_aux}); end
    exp_last_aux = 1'b0;
    bus.req_aux = 1'b1; bus.force_release = 1'b1;
    bad = 1'b0;
    repeat ($urandom_range(1, 3)) begin
      cyc(1'b0);
      if ({bus.grant_pi, bus.grant_aux} !== 2'b10) bad = 1'b1;
    end
    checks++; if (bad) begin failures++; $display("FAIL force_busy_stable: pi access interrupted before cyc_done"); end
    bus.cyc_done = 1'b1;
    cyc(1'b0);
    checks++; if ({bus.done_pi, bus.grant_pi, bus.grant_aux} !== 3'b100) begin failures++; $display("FAIL force_busy_done: got %b want 100", {bus.done_pi, bus.grant_pi, bus.grant_aux}); end
    bus.req_pi = 1'b0;
    cyc(1'b0);
    checks++; if ({bus.bgack_drive, bus.grant_aux, bus.bus_owned, bus.done_aux} !== 4'b0000) begin failures++; $display("FAIL force_busy_release: got %b want 0000", {bus.bgack_drive, bus.grant_aux, bus.bus_owned, bus.done_aux}); end
    bus.force_release = 1'b0; bus.req_aux = 1'b0;
    cyc(1'b0);
  endtask

  task automatic test_reset_busy();
    bus.req_pi = 1'b1;
    cyc(1'b0);
    acquire(1, 1);
    cyc(1'b0);
    checks++; if ({bus.grant_pi, bus.grant_aux} !== 2'b10) begin failures++; $display("FAIL rstbusy_grant: got %b want 10", {bus.grant_pi, bus.grant_aux}); end
    exp_last_aux = 1'b0;
    bus.req_aux = 1'b1;
    cyc(1'b0);
    #2;
    nRESET = 1'b0;
    #1;
    checks++; if (outs !== 8'h00) begin failures++; $display("FAIL rstbusy_async: got %b want 00000000", outs); end
    bus.cyc_done = 1'b1;
    cyc(1'b0);
    checks++; if (outs !== 8'h00) begin failures++; $display("FAIL rstbusy_no_done: got %b want 00000000", outs); end
    exp_last_aux = 1'b1;
    nRESET = 1'b1;
    cyc(1'b0);
    acquire(0, 0);
    cyc(1'b0);
    checks++; if ({bus.grant_pi, bus.grant_aux} !== {exp_last_aux, ~exp_last_aux}) begin failures++; $display("FAIL rstbusy_first_pi: got %b want 10", {bus.grant_pi, bus.grant_aux}); end
    exp_last_aux = 1'b0;
    bus.cyc_done = 1'b1;
    cyc(1'b0);
    bus.req_pi = 1'b0;
    cyc(1'b0);
    checks++; if ({bus.grant_pi, bus.grant_aux} !== 2'b01) begin failures++; $display("FAIL rstbusy_then_aux: got %b want 01", {bus.grant_pi, bus.grant_aux}); end
    bus.cyc_done = 1'b1;
    cyc(1'b0);
    checks++; if (bus.done_aux !== 1'b1) begin failures++; $display("FAIL rstbusy_done_aux: got %b want 1", bus.done_aux); end
    bus.req_aux = 1'b0; bus.force_release = 1'b1;
    cyc(1'b0);
    cyc(1'b0);
    bus.force_release = 1'b0;
  endtask

  initial begin
    bus.mc_clk_fall   = 1'b0;
    bus.req_pi        = 1'b0;
    bus.req_aux       = 1'b0;
    bus.cyc_done      = 1'b0;
    bus.bg_n          = 1'b1;
    bus.as_n          = 1'b1;
    bus.dtack_n       = 1'b1;
    bus.bgack_n       = 1'b1;
    bus.force_release = 1'b0;
    exp_last_aux      = 1'b1;
    test_reset();
    test_single();
    test_contention();
    test_timeout();
    test_force();
    test_reset_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
